// File: rtl/i2c_regfile_pkg.sv
// i2c_regfile_pkg: register map, bit indices and reset values shared by the register file.
package i2c_regfile_pkg;

    localparam logic [7:0] DEVICE_ID      = 8'hA5;
    localparam logic [7:0] VERSION        = 8'h12;
    localparam logic [7:0] RDATA_UNMAPPED = 8'hEE;

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_VER     = 8'h01;
    localparam logic [7:0] ADDR_SCRATCH = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h03;
    localparam logic [7:0] ADDR_LED     = 8'h04;
    localparam logic [7:0] ADDR_STATUS  = 8'h05;
    localparam logic [7:0] ADDR_WR_CNT  = 8'h06;
    localparam logic [7:0] ADDR_TS0     = 8'h08;
    localparam logic [7:0] ADDR_TS1     = 8'h09;
    localparam logic [7:0] ADDR_TS2     = 8'h0A;
    localparam logic [7:0] ADDR_TS3     = 8'h0B;

    localparam int CTRL_LED_EN   = 0;
    localparam int CTRL_TS_RUN   = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_SOFT_RST = 7;

    localparam int ST_WR_SEEN = 0;
    localparam int ST_RD_SEEN = 1;
    localparam int ST_BAD_WR  = 2;

    localparam logic [7:0] SCRATCH_RST = 8'h00;
    localparam logic [2:0] CTRL_RST    = 3'b000;
    localparam logic [7:0] LED_RST     = 8'h00;
    localparam logic [2:0] STICKY_RST  = 3'b000;
    localparam logic [7:0] WR_CNT_RST  = 8'h00;
    localparam logic [7:0] RDATA_RST   = 8'h00;

    // Only these four registers accept writes; everything else flags bad_wr.
    function automatic logic addr_writable(input logic [7:0] a);
        return a inside {ADDR_SCRATCH, ADDR_CTRL, ADDR_LED, ADDR_STATUS};
    endfunction

endpackage

// File: rtl/i2c_regfile_if.sv
// i2c_regfile_if: register strobe bus between the I2C slave (master side) and the register file.
interface i2c_regfile_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;

    modport master (output reg_addr, reg_wdata, reg_wr, reg_rd, input reg_rdata);
    modport slave  (input reg_addr, reg_wdata, reg_wr, reg_rd, output reg_rdata);
endinterface

// File: rtl/i2c_ts_counter.sv
// i2c_ts_counter: free-running 32-bit timestamp with a snapshot register for atomic byte reads.
module i2c_ts_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        run,
    input  logic        snap,
    output logic [31:0] snap_o
);
    logic [31:0] cnt_q, cnt_d, snap_q, snap_d;

    assign cnt_d  = run ? cnt_q + 32'd1 : cnt_q;
    assign snap_d = snap ? cnt_q : snap_q;
    assign snap_o = snap_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end
endmodule

// File: rtl/i2c_regfile.sv
// i2c_regfile: byte register file behind the I2C slave with LED control, sticky status and IRQ.
// Define I2C_REGFILE_TS_EN to include the timestamp counter/snapshot at 0x08-0x0B.
module i2c_regfile
    import i2c_regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    i2c_regfile_if.slave        bus,
    input  logic [3:0]          status_i,
    output logic [7:0]          led_o,
    output logic                irq_o
);
    logic [7:0] scratch_q, scratch_d, led_q, led_d, wr_cnt_q, wr_cnt_d;
    logic [7:0] rdata_q, rdata_d, led_out_q;
    logic [2:0] ctrl_q, ctrl_d, sticky_q, sticky_d, w1c;
    logic       rd_q, irq_q, rd_rise, wr_ok, wr_bad, soft_rst;

`ifdef I2C_REGFILE_TS_EN
    localparam logic [2:0] CTRL_WMASK = 3'b111;
    logic [31:0] snap;

    i2c_ts_counter u_ts (
        .clk    (clk),
        .rst    (rst),
        .clr    (soft_rst),
        .run    (ctrl_q[CTRL_TS_RUN]),
        .snap   (rd_rise && bus.reg_addr == ADDR_TS0),
        .snap_o (snap)
    );
`else
    localparam logic [2:0] CTRL_WMASK = 3'b101;
`endif

    assign rd_rise  = bus.reg_rd & ~rd_q;
    assign wr_ok    = bus.reg_wr & addr_writable(bus.reg_addr);
    assign wr_bad   = bus.reg_wr & ~wr_ok;
    assign soft_rst = wr_ok && bus.reg_addr == ADDR_CTRL && bus.reg_wdata[CTRL_SOFT_RST];

    always_comb begin
        scratch_d = (wr_ok && bus.reg_addr == ADDR_SCRATCH) ? bus.reg_wdata : scratch_q;
        ctrl_d    = (wr_ok && bus.reg_addr == ADDR_CTRL) ? bus.reg_wdata[2:0] & CTRL_WMASK : ctrl_q;
        led_d     = (wr_ok && bus.reg_addr == ADDR_LED) ? bus.reg_wdata : led_q;
        wr_cnt_d  = wr_ok ? wr_cnt_q + 8'd1 : wr_cnt_q;
        w1c       = (wr_ok && bus.reg_addr == ADDR_STATUS) ? bus.reg_wdata[2:0] : 3'b000;
        // Clear first, then OR in this cycle's events so a hardware set beats W1C.
        sticky_d  = (sticky_q & ~w1c) | {wr_bad, rd_rise, wr_ok};
    end

    always_comb begin
        rdata_d = RDATA_UNMAPPED;
        case (bus.reg_addr)
            ADDR_ID:      rdata_d = DEVICE_ID;
            ADDR_VER:     rdata_d = VERSION;
            ADDR_SCRATCH: rdata_d = scratch_q;
            ADDR_CTRL:    rdata_d = {5'b00000, ctrl_q};
            ADDR_LED:     rdata_d = led_q;
            ADDR_STATUS:  rdata_d = {status_i, 1'b0, sticky_q};
            ADDR_WR_CNT:  rdata_d = wr_cnt_q;
`ifdef I2C_REGFILE_TS_EN
            ADDR_TS0:     rdata_d = snap[7:0];
            ADDR_TS1:     rdata_d = snap[15:8];
            ADDR_TS2:     rdata_d = snap[23:16];
            ADDR_TS3:     rdata_d = snap[31:24];
`endif
            default:      rdata_d = RDATA_UNMAPPED;
        endcase
    end

    // soft_rst takes precedence over every update carried by the same write.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            scratch_q <= SCRATCH_RST;
            ctrl_q    <= CTRL_RST;
            led_q     <= LED_RST;
            sticky_q  <= STICKY_RST;
            wr_cnt_q  <= WR_CNT_RST;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            led_q     <= led_d;
            sticky_q  <= sticky_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 1'b0;
            rdata_q   <= RDATA_RST;
            led_out_q <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            rd_q      <= bus.reg_rd;
            rdata_q   <= rdata_d;
            led_out_q <= ctrl_q[CTRL_LED_EN] ? led_q : 8'h00;
            irq_q     <= ctrl_q[CTRL_IRQ_EN] & |sticky_q;
        end
    end

    assign bus.reg_rdata = rdata_q;
    assign led_o         = led_out_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_i2c_regfile.sv
// tb_i2c_regfile: directed and randomized checks of i2c_regfile against a register-map model.
module tb_i2c_regfile;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] status_i = 4'h0;
    logic [7:0] led_o;
    logic       irq_o;

    i2c_regfile_if bus();

    i2c_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .status_i (status_i),
        .led_o    (led_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

`ifdef I2C_REGFILE_TS_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_scratch, m_ctrl, m_led, m_wrcnt;
    logic [2:0]  m_sticky;
    logic        m_rdq;
    logic [31:0] m_ts, m_snap;
    logic [7:0]  e_rdata, e_led;
    logic        e_irq;

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int idx;
        if (a == 8'h00) return 8'hA5;
        if (a == 8'h01) return 8'h12;
        if (a == 8'h02) return m_scratch;
        if (a == 8'h03) return m_ctrl;
        if (a == 8'h04) return m_led;
        if (a == 8'h05) return {status_i, 1'b0, m_sticky};
        if (a == 8'h06) return m_wrcnt;
        if (TS && a >= 8'h08 && a <= 8'h0B) begin
            idx = int'(a) - 8;
            return m_snap[idx*8 +: 8];
        end
        return 8'hEE;
    endfunction

    task automatic model_clear();
        m_scratch = 8'h00;
        m_ctrl    = 8'h00;
        m_led     = 8'h00;
        m_wrcnt   = 8'h00;
        m_sticky  = 3'b000;
        m_ts      = 32'd0;
        m_snap    = 32'd0;
    endtask

    // Drives one clock of bus activity, advances the model, returns at the next negedge.
    task automatic cycle(input logic wr, input logic rd, input logic [7:0] addr, input logic [7:0] wdata);
        logic ok, rise, run;
        logic [2:0] st;
        bus.reg_wr    = wr;
        bus.reg_rd    = rd;
        bus.reg_addr  = addr;
        bus.reg_wdata = wdata;
        rise = rd && !m_rdq;
        ok   = wr && addr >= 8'h02 && addr <= 8'h05;
        run  = m_ctrl[1];
        e_rdata = model_read(addr);
        e_led   = m_ctrl[0] ? m_led : 8'h00;
        e_irq   = m_ctrl[2] && m_sticky != 3'b000;
        if (ok && addr == 8'h03 && wdata[7]) begin
            model_clear();
        end else begin
            st = m_sticky;
            if (ok && addr == 8'h05) st = st & ~wdata[2:0];
            if (ok) begin
                st[0] = 1'b1;
                m_wrcnt = m_wrcnt + 8'd1;
            end
            if (wr && !ok) st[2] = 1'b1;
            if (rise) begin
                st[1] = 1'b1;
                if (TS && addr == 8'h08) m_snap = m_ts;
            end
            if (ok && addr == 8'h02) m_scratch = wdata;
            if (ok && addr == 8'h03) m_ctrl = {5'b00000, wdata[2], wdata[1] & TS, wdata[0]};
            if (ok && addr == 8'h04) m_led = wdata;
            if (TS && run) m_ts = m_ts + 32'd1;
            m_sticky = st;
        end
        m_rdq = rd;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic hold_rd);
        rst = 1'b1;
        bus.reg_wr    = 1'b0;
        bus.reg_rd    = hold_rd;
        bus.reg_addr  = 8'h00;
        bus.reg_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        m_rdq   = 1'b0;
        e_rdata = 8'h00;
        e_led   = 8'h00;
        e_irq   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected %h", bus.reg_rdata, 8'h00); end
        checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected %h", led_o, 8'h00); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected %b", irq_o, 1'b0); end
        cycle(1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (bus.reg_rdata !== 8'hA5) begin errors++; $display("FAIL read_id: got %h expected %h", bus.reg_rdata, 8'hA5); end
        cycle(1'b0, 1'b0, 8'h01, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h12) begin errors++; $display("FAIL read_ver: got %h expected %h", bus.reg_rdata, 8'h12); end
        cycle(1'b0, 1'b0, 8'h07, 8'h00);
        checks++; if (bus.reg_rdata !== 8'hEE) begin errors++; $display("FAIL read_unmapped: got %h expected %h", bus.reg_rdata, 8'hEE); end
    endtask

    task automatic test_led();
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 8'h04, 8'h3C);
        cycle(1'b1, 1'b0, 8'h03, 8'h01);
        checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL led_before_en: got %h expected %h", led_o, 8'h00); end
        cycle(1'b0, 1'b0, 8'h06, 8'h00);
        checks++; if (led_o !== 8'h3C) begin errors++; $display("FAIL led_after_en: got %h expected %h", led_o, 8'h3C); end
        checks++; if (bus.reg_rdata !== 8'h02) begin errors++; $display("FAIL led_wr_cnt: got %h expected %h", bus.reg_rdata, 8'h02); end
    endtask

    task automatic test_bad_wr();
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 8'h03, 8'h04);
        cycle(1'b1, 1'b0, 8'h00, 8'hFF);
        cycle(1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (bus.reg_rdata !== 8'hA5) begin errors++; $display("FAIL id_after_wr: got %h expected %h", bus.reg_rdata, 8'hA5); end
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL bad_wr_irq: got %b expected %b", irq_o, 1'b1); end
        cycle(1'b0, 1'b0, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h05) begin errors++; $display("FAIL bad_wr_status: got %h expected %h", bus.reg_rdata, 8'h05); end
        cycle(1'b0, 1'b0, 8'h06, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h01) begin errors++; $display("FAIL bad_wr_cnt: got %h expected %h", bus.reg_rdata, 8'h01); end
        cycle(1'b1, 1'b0, 8'h05, 8'h04);
        cycle(1'b0, 1'b0, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h01) begin errors++; $display("FAIL bad_wr_cleared: got %h expected %h", bus.reg_rdata, 8'h01); end
        checks++; if (irq_o !== e_irq) begin errors++; $display("FAIL irq_after_w1c: got %b expected %b", irq_o, e_irq); end
        cycle(1'b0, 1'b0, 8'h06, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h02) begin errors++; $display("FAIL status_wr_cnt: got %h expected %h", bus.reg_rdata, 8'h02); end
    endtask

    task automatic test_w1c_race();
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 8'h02, 8'hAA);
        cycle(1'b0, 1'b1, 8'h02, 8'h00);
        cycle(1'b1, 1'b0, 8'h05, 8'h01);
        cycle(1'b0, 1'b0, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h03) begin errors++; $display("FAIL wr_seen_set_wins: got %h expected %h", bus.reg_rdata, 8'h03); end
        cycle(1'b1, 1'b0, 8'h05, 8'h02);
        cycle(1'b0, 1'b0, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h01) begin errors++; $display("FAIL rd_seen_w1c: got %h expected %h", bus.reg_rdata, 8'h01); end
        cycle(1'b1, 1'b1, 8'h05, 8'h02);
        cycle(1'b0, 1'b1, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h03) begin errors++; $display("FAIL rd_seen_set_wins: got %h expected %h", bus.reg_rdata, 8'h03); end
        cycle(1'b0, 1'b0, 8'h06, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h04) begin errors++; $display("FAIL wr_and_rd_cnt: got %h expected %h", bus.reg_rdata, 8'h04); end
    endtask

    task automatic test_wrap_soft_rst();
        do_reset(1'b0);
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, 8'h02, 8'(i));
        cycle(1'b0, 1'b0, 8'h06, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL wr_cnt_wrap: got %h expected %h", bus.reg_rdata, 8'h00); end
        cycle(1'b0, 1'b0, 8'h02, 8'h00);
        checks++; if (bus.reg_rdata !== 8'hFF) begin errors++; $display("FAIL scratch_last: got %h expected %h", bus.reg_rdata, 8'hFF); end
        cycle(1'b1, 1'b0, 8'h04, 8'h11);
        cycle(1'b1, 1'b0, 8'h03, 8'h05);
        cycle(1'b1, 1'b0, 8'h03, 8'h85);
        cycle(1'b0, 1'b0, 8'h02, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL soft_rst_scratch: got %h expected %h", bus.reg_rdata, 8'h00); end
        cycle(1'b0, 1'b0, 8'h06, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL soft_rst_wr_cnt: got %h expected %h", bus.reg_rdata, 8'h00); end
        cycle(1'b0, 1'b0, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL soft_rst_status: got %h expected %h", bus.reg_rdata, 8'h00); end
        cycle(1'b0, 1'b0, 8'h03, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL soft_rst_ctrl: got %h expected %h", bus.reg_rdata, 8'h00); end
        cycle(1'b0, 1'b0, 8'h04, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL soft_rst_led_reg: got %h expected %h", bus.reg_rdata, 8'h00); end
        checks++; if (led_o !== 8'h00 || irq_o !== 1'b0) begin errors++; $display("FAIL soft_rst_outputs: got led=%h irq=%b expected led=00 irq=0", led_o, irq_o); end
    endtask

    task automatic test_rst_mid();
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 8'h02, 8'h55);
        cycle(1'b0, 1'b1, 8'h05, 8'h00);
        do_reset(1'b1);
        cycle(1'b0, 1'b1, 8'h02, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_scratch: got %h expected %h", bus.reg_rdata, 8'h00); end
        cycle(1'b0, 1'b1, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h02) begin errors++; $display("FAIL rst_mid_rd_rise: got %h expected %h", bus.reg_rdata, 8'h02); end
    endtask

`ifdef I2C_REGFILE_TS_EN
    task automatic test_timestamp();
        logic [31:0] v;
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 8'h03, 8'h02);
        repeat (1000) cycle(1'b0, 1'b0, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 8'h08, 8'h00);
        for (int i = 0; i < 49; i++) begin
            cycle(1'b0, 1'b1, 8'h08, 8'h00);
            checks++; if (bus.reg_rdata !== e_rdata) begin errors++; $display("FAIL ts_held_%0d: got %h expected %h", i, bus.reg_rdata, e_rdata); end
        end
        cycle(1'b0, 1'b0, 8'h08, 8'h00); v[7:0]   = bus.reg_rdata;
        cycle(1'b0, 1'b0, 8'h09, 8'h00); v[15:8]  = bus.reg_rdata;
        cycle(1'b0, 1'b0, 8'h0A, 8'h00); v[23:16] = bus.reg_rdata;
        cycle(1'b0, 1'b0, 8'h0B, 8'h00); v[31:24] = bus.reg_rdata;
        checks++; if (v < 32'd996 || v > 32'd1004) begin errors++; $display("FAIL ts_range: got %0d expected 996..1004", v); end
        checks++; if (v !== m_snap) begin errors++; $display("FAIL ts_value: got %0d expected %0d", v, m_snap); end
    endtask
`else
    task automatic test_ts_absent();
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 8'h08, 8'h12);
        cycle(1'b0, 1'b1, 8'h08, 8'h00);
        checks++; if (bus.reg_rdata !== 8'hEE) begin errors++; $display("FAIL ts_unmapped: got %h expected %h", bus.reg_rdata, 8'hEE); end
        cycle(1'b1, 1'b0, 8'h03, 8'h07);
        cycle(1'b0, 1'b0, 8'h03, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h05) begin errors++; $display("FAIL ctrl_ts_run_masked: got %h expected %h", bus.reg_rdata, 8'h05); end
        cycle(1'b0, 1'b0, 8'h05, 8'h00);
        checks++; if (bus.reg_rdata !== 8'h07) begin errors++; $display("FAIL ts_wr_bad: got %h expected %h", bus.reg_rdata, 8'h07); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] a, d;
        logic w, r;
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 12) == 12) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 11));
            d = 8'($urandom);
            if (a == 8'h03 && $urandom_range(0, 15) != 0) d[7] = 1'b0;
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 0);
            status_i = 4'($urandom);
            cycle(w, r, a, d);
            checks++; if (bus.reg_rdata !== e_rdata) begin errors++; $display("FAIL rand_rdata_%0d: got %h expected %h", i, bus.reg_rdata, e_rdata); end
            checks++; if (led_o !== e_led) begin errors++; $display("FAIL rand_led_%0d: got %h expected %h", i, led_o, e_led); end
            checks++; if (irq_o !== e_irq) begin errors++; $display("FAIL rand_irq_%0d: got %b expected %b", i, irq_o, e_irq); end
        end
        status_i = 4'h0;
    endtask

    initial begin
        test_reset();
        test_led();
        test_bad_wr();
        test_w1c_race();
        test_wrap_soft_rst();
        test_rst_mid();
`ifdef I2C_REGFILE_TS_EN
        test_timestamp();
`else
        test_ts_absent();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
